// File: rtl/dma_copy_engine.sv
// dma_copy_engine
//   Bus-master copy engine for the DMA memory block. Moves a block of words
//   from a source region to a destination region through the memory's
//   single-port WR/addr/data interface. The copy direction is chosen so that
//   overlapping regions copy correctly, memmove-style.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   start               one-cycle copy request, only looked at in IDLE
//   src_addr, dst_addr  first source / destination word address
//   length              number of words to copy
//   busy                copy in progress (CHECK through the last WR)
//   done, error         one-cycle completion pulse; error marks a rejected request
//   words_done          words written so far; held until the next accepted start
//   mem_WR, mem_addr    memory strobe (1 = write, 0 = read) and address
//   mem_data            shared data bus; driven here only while mem_WR = 1
module dma_copy_engine #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_done,
  output logic              mem_WR,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  typedef enum logic [2:0] {IDLE, CHECK, RD_ADDR, RD_CAP, WR, FIN} state_t;

  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q, len_q;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, remain;
  logic              desc_q, err_q;
  logic [DATA_W-1:0] data_q;

  // End addresses carry one extra bit so a request running past the top of
  // the address space is caught instead of wrapping into a small value.
  logic [ADDR_W:0] src_end, dst_end;
  logic            range_bad, overlap_hi;

  assign src_end    = {1'b0, src_q} + {1'b0, len_q};
  assign dst_end    = {1'b0, dst_q} + {1'b0, len_q};
  assign range_bad  = (src_end > DEPTH) || (dst_end > DEPTH);
  // Destination starts inside the source block: walk both regions top-down so
  // no source word is overwritten before it has been read.
  assign overlap_hi = (dst_q > src_q) && ({1'b0, dst_q} < src_end);

  // The engine only ever drives the bus during its own write cycle.
  assign mem_data = mem_WR ? data_q : {DATA_W{1'bz}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    mem_WR    = 1'b0;
    mem_addr  = '0;
    unique case (state)
      IDLE: if (start) state_nxt = CHECK;
      CHECK: begin
        busy = 1'b1;
        if (len_q == '0 || range_bad) state_nxt = FIN;
        else                          state_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        busy      = 1'b1;
        mem_addr  = src_ptr;
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        // Address held so the memory's registered read lines up with capture.
        busy      = 1'b1;
        mem_addr  = src_ptr;
        state_nxt = WR;
      end
      WR: begin
        busy      = 1'b1;
        mem_WR    = 1'b1;
        mem_addr  = dst_ptr;
        state_nxt = (remain == ONE) ? FIN : RD_ADDR;
      end
      FIN: begin
        done      = 1'b1;
        error     = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      remain     <= '0;
      desc_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      words_done <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          src_q      <= src_addr;
          dst_q      <= dst_addr;
          len_q      <= length;
          err_q      <= 1'b0;
          words_done <= '0;
        end
        CHECK: begin
          // A zero-length request completes cleanly whatever its addresses.
          err_q  <= (len_q != '0) && range_bad;
          desc_q <= overlap_hi;
          remain <= len_q;
          if (overlap_hi) begin
            src_ptr <= src_end[ADDR_W-1:0] - ONE;
            dst_ptr <= dst_end[ADDR_W-1:0] - ONE;
          end else begin
            src_ptr <= src_q;
            dst_ptr <= dst_q;
          end
        end
        RD_CAP: data_q <= mem_data;
        WR: begin
          words_done <= words_done + ONE;
          remain     <= remain - ONE;
          if (desc_q) begin
            src_ptr <= src_ptr - ONE;
            dst_ptr <= dst_ptr - ONE;
          end else begin
            src_ptr <= src_ptr + ONE;
            dst_ptr <= dst_ptr + ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine
//   Bench for dma_copy_engine: a memory that follows the WR/addr/data
//   contract, a per-cycle timeline model of the copy engine, and a memmove
//   image model of what memory must hold after each request.
module tb_dma_copy_engine;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 192;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr, length;
  logic          busy, done, error, mem_WR;
  logic [AW-1:0] words_done, mem_addr;
  wire  [DW-1:0] mem_data;

  int checks;
  int failures;

  dma_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .mem_WR(mem_WR), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory ----------------
  logic [DW-1:0] mem   [256];
  logic [DW-1:0] stage [256];
  logic [DW-1:0] rd_q;
  logic          ld;

  always @(posedge clk) begin
    if (ld) for (int i = 0; i < 256; i++) mem[i] <= stage[i];
    else if (mem_WR) mem[mem_addr] <= mem_data;
    if (!mem_WR) rd_q <= mem[mem_addr];
  end
  assign mem_data = mem_WR ? {DW{1'bz}} : rd_q;

  // ---------------- reference model ----------------
  // k = cycle index since the accepted start edge (0 = idle).
  int k;
  int m_src, m_dst, m_len, hold_wd;
  logic [DW-1:0] orig    [256];
  logic [DW-1:0] exp_mem [256];

  function automatic bit rej(input int s, input int d, input int l);
    return (l != 0) && ((s + l > DEPTH) || (d + l > DEPTH));
  endfunction

  function automatic int total(input int s, input int d, input int l);
    return (l == 0 || rej(s, d, l)) ? 2 : 3 * l + 2;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k       <= 0;
      hold_wd <= 0;
    end else if (k == 0) begin
      if (start) begin
        k     <= 1;
        m_src <= int'(src_addr);
        m_dst <= int'(dst_addr);
        m_len <= int'(length);
      end
    end else if (k == total(m_src, m_dst, m_len)) begin
      k       <= 0;
      hold_wd <= rej(m_src, m_dst, m_len) ? 0 : m_len;
    end else begin
      k <= k + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the timeline model.
  task automatic cmp();
    int n, tot, j, ph, sa, da, e_wd;
    bit rj, dsc, inw, e_wr;
    n   = m_len;
    rj  = rej(m_src, m_dst, m_len);
    tot = total(m_src, m_dst, m_len);
    dsc = (m_dst > m_src) && (m_dst < m_src + n);
    inw = (k != 0) && (tot != 2) && (k >= 2) && (k <= 3 * n + 1);
    j   = (k - 2) / 3;
    ph  = (k - 2) % 3;
    sa  = dsc ? m_src + n - 1 - j : m_src + j;
    da  = dsc ? m_dst + n - 1 - j : m_dst + j;
    e_wr = inw && (ph == 2);
    if (k == 0)        e_wd = hold_wd;
    else if (k == 1)   e_wd = 0;
    else if (k < tot)  e_wd = j;
    else               e_wd = (rj || n == 0) ? 0 : n;
    chk("busy",       32'(busy),       32'(k >= 1 && k < tot));
    chk("done",       32'(done),       32'(k != 0 && k == tot));
    chk("error",      32'(error),      32'(k != 0 && k == tot && rj));
    chk("words_done", 32'(words_done), 32'(e_wd));
    chk("mem_WR",     32'(mem_WR),     32'(e_wr));
    if (inw) chk("mem_addr", 32'(mem_addr), 32'((ph < 2) ? sa : da));
    if (e_wr) chk("wr_data", mem_data, orig[sa]);
    if (mem_WR !== 1'b1) chk("bus_release", mem_data, rd_q);
  endtask

  task automatic tick();
    @(negedge clk);
    cmp();
  endtask

  task automatic load();
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic snap();
    for (int i = 0; i < 256; i++) stage[i] = mem[i];
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk(name, 32'(bad), 32'(0));
  endtask

  task automatic prep(input int s, input int d, input int l);
    for (int i = 0; i < 256; i++) begin
      orig[i]    = mem[i];
      exp_mem[i] = mem[i];
    end
    // memmove semantics: destination ends up with the original source words.
    if (!rej(s, d, l) && l != 0)
      for (int i = 0; i < l; i++) exp_mem[d + i] = orig[s + i];
  endtask

  task automatic run_copy(input int s, input int d, input int l, input int poke,
                          output int done_at, output bit err_seen, output bit wr_seen);
    int t;
    prep(s, d, l);
    done_at = -1; err_seen = 1'b0; wr_seen = 1'b0; t = 0;
    src_addr = AW'(s); dst_addr = AW'(d); length = AW'(l); start = 1'b1;
    do begin
      tick();
      t++;
      if (done === 1'b1 && done_at < 0) done_at = t;
      if (error === 1'b1) err_seen = 1'b1;
      if (mem_WR === 1'b1) wr_seen = 1'b1;
      if (t == poke && k != 0) begin
        // A request while busy or in FIN must be ignored.
        start = 1'b1;
        src_addr = AW'($urandom); dst_addr = AW'($urandom); length = AW'($urandom);
      end else begin
        start = 1'b0;
      end
    end while (k != 0 && t < 1000);
    start = 1'b0;
    chk("copy_terminates", 32'(k), 32'(0));
    check_mem("mem_image");
  endtask

  initial begin
    int da; bit es, ws;
    int s, d, l, p;
    checks = 0; failures = 0;
    src_addr = '0; dst_addr = '0; length = '0; start = 1'b0; ld = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) stage[i] = $urandom;
    #1;
    chk("rst_busy",     32'(busy),       32'(0));
    chk("rst_done",     32'(done),       32'(0));
    chk("rst_error",    32'(error),      32'(0));
    chk("rst_wd",       32'(words_done), 32'(0));
    chk("rst_mem_WR",   32'(mem_WR),     32'(0));
    chk("rst_mem_addr", 32'(mem_addr),   32'(0));
    load();
    tick();
    reset = 1'b0;
    tick();

    // Basic copy: mem[1..3] -> mem[10..12]
    snap(); stage[1] = 8; stage[2] = 9; stage[3] = 12; load();
    run_copy(1, 10, 3, 0, da, es, ws);
    chk("basic_done_cycle", 32'(da), 32'(11));
    chk("basic_error",      32'(es), 32'(0));
    chk("basic_wd",         32'(words_done), 32'(3));
    chk("basic_m10", mem[10], 32'd8);
    chk("basic_m11", mem[11], 32'd9);
    chk("basic_m12", mem[12], 32'd12);
    tick(); tick();
    chk("wd_hold", 32'(words_done), 32'(3));

    // Overlap, destination above source: must copy top-down.
    snap(); stage[0] = 'hA; stage[1] = 'hB; stage[2] = 'hC; stage[3] = 'hD; load();
    run_copy(0, 2, 4, 0, da, es, ws);
    chk("ovf_m2", mem[2], 32'hA);
    chk("ovf_m3", mem[3], 32'hB);
    chk("ovf_m4", mem[4], 32'hC);
    chk("ovf_m5", mem[5], 32'hD);
    chk("ovf_done_cycle", 32'(da), 32'(14));

    // Overlap, destination below source: bottom-up.
    snap(); stage[2] = 5; stage[3] = 6; stage[4] = 7; load();
    run_copy(2, 0, 3, 0, da, es, ws);
    chk("ovb_m0", mem[0], 32'd5);
    chk("ovb_m1", mem[1], 32'd6);
    chk("ovb_m2", mem[2], 32'd7);

    // Range error and zero length.
    run_copy(190, 0, 3, 0, da, es, ws);
    chk("rng_done_cycle", 32'(da), 32'(2));
    chk("rng_error",      32'(es), 32'(1));
    chk("rng_no_write",   32'(ws), 32'(0));
    run_copy(5, 185, 8, 0, da, es, ws);
    chk("rng_dst_error",  32'(es), 32'(1));
    run_copy(7, 20, 0, 0, da, es, ws);
    chk("len0_done_cycle", 32'(da), 32'(2));
    chk("len0_error",      32'(es), 32'(0));
    chk("len0_no_write",   32'(ws), 32'(0));
    run_copy(188, 188, 4, 0, da, es, ws);
    chk("top_edge_error",  32'(es), 32'(0));
    run_copy(30, 30, 4, 0, da, es, ws);
    chk("same_addr_error", 32'(es), 32'(0));

    // Reset during RD_CAP of the third word.
    prep(20, 60, 5);
    for (int i = 0; i < 256; i++) exp_mem[i] = orig[i];
    exp_mem[60] = orig[20];
    exp_mem[61] = orig[21];
    src_addr = 8'd20; dst_addr = 8'd60; length = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("mid_wd", 32'(words_done), 32'(2));
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_busy",   32'(busy),       32'(0));
    chk("mid_rst_done",   32'(done),       32'(0));
    chk("mid_rst_wd",     32'(words_done), 32'(0));
    chk("mid_rst_WR",     32'(mem_WR),     32'(0));
    chk("mid_rst_addr",   32'(mem_addr),   32'(0));
    tick(); tick();
    reset = 1'b0;
    tick();
    check_mem("mid_rst_image");
    run_copy(20, 60, 5, 0, da, es, ws);
    chk("after_rst_done_cycle", 32'(da), 32'(17));

    // Randomized copies, with stray start pulses while busy / in FIN.
    for (int it = 0; it < 40; it++) begin
      if (it % 10 == 0) begin
        for (int i = 0; i < 256; i++) stage[i] = $urandom;
        load();
      end
      l = $urandom_range(0, 12);
      if ($urandom_range(0, 5) == 0) begin
        s = $urandom_range(0, 255);
        d = $urandom_range(0, 255);
      end else begin
        s = $urandom_range(0, DEPTH - 1 - l);
        if ($urandom_range(0, 1) == 0) d = s + $urandom_range(0, 6) - 3;
        else                           d = $urandom_range(0, DEPTH - 1 - l);
        if (d < 0) d = 0;
      end
      p = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3 * l + 2) : 0;
      run_copy(s, d, l, p, da, es, ws);
      if ($urandom_range(0, 1) == 0) tick();
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

endmodule
